apb_arb_master: RTL and testbench

- Two-port APB master that shares one APB slave (the 1K×32 APB RAM) between two local requesters.
- Arbitrates with round-robin priority and latches the winning request.
- Sequences APB IDLE→SETUP→ACCESS phases and waits on PREADY.
- Returns read data and a done pulse to the granted requester. Sits between CPU/DMA-side logic and the APB RAM.

---
 rtl/apb_arb_master_if.sv | 24 ++
 rtl/apb_arb_master.sv | 143 ++++++++++++++
 tb/tb_apb_arb_master.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_arb_master_if.sv
// APB bus bundle between apb_arb_master and its slave.
// Master drives select/enable/address/data; slave answers.
interface apb_arb_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_arb_master.sv
// Two-requester round-robin APB master (IDLE/SETUP/ACCESS).
// Optional macro APB_TIMEOUT_EN: abort ACCESS after TIMEOUT cycles.
module apb_arb_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic [DATA_W-1:0] rdata0,
  output logic              done0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata1,
  output logic              done1,
  output logic              err1,
  output logic              busy,
  apb_arb_master_if.master  apb
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state;
  logic   ptr;
  logic   gnt;
  logic   r0;
  logic   r1;
  logic   win;

  // Mask the requester being acknowledged so a held req is not re-granted.
  always_comb begin
    r0  = req0 & ~done0;
    r1  = req1 & ~done1;
    win = (r0 & r1) ? ptr : r1;
  end

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`else
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  // Arbitration, APB phase sequencing and completion reporting.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      gnt         <= 1'b0;
      busy        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      apb.PSEL    <= 1'b0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
`ifdef APB_TIMEOUT_EN
      err0        <= 1'b0;
      err1        <= 1'b0;
      cnt         <= '0;
`endif
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
`ifdef APB_TIMEOUT_EN
      err0  <= 1'b0;
      err1  <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (r0 | r1) begin
            gnt         <= win;
            apb.PWRITE  <= win ? we1 : we0;
            apb.PADDR   <= win ? addr1 : addr0;
            apb.PWDATA  <= win ? wdata1 : wdata0;
            apb.PSEL    <= 1'b1;
            apb.PENABLE <= 1'b0;
            busy        <= 1'b1;
            state       <= SETUP;
          end
        end
        SETUP: begin
          apb.PENABLE <= 1'b1;
          state       <= ACCESS;
`ifdef APB_TIMEOUT_EN
          cnt         <= CW'(1);
`endif
        end
        ACCESS: begin
          if (apb.PREADY) begin
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
            ptr         <= ~gnt;
            if (gnt) begin
              done1 <= 1'b1;
              if (!apb.PWRITE) rdata1 <= apb.PRDATA;
            end else begin
              done0 <= 1'b1;
              if (!apb.PWRITE) rdata0 <= apb.PRDATA;
            end
          end
`ifdef APB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT)) begin
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
            ptr         <= ~gnt;
            if (gnt) begin
              done1 <= 1'b1;
              err1  <= 1'b1;
            end else begin
              done0 <= 1'b1;
              err0  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master with a 1Kx32 APB RAM model and a
// scoreboard of expected completions.
module tb_apb_arb_master;
  localparam int AW = 12;
  localparam int DW = 32;

  typedef struct {
    int          id;
    bit          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit          err;
  } exp_t;

  logic PCLK = 1'b0;
  logic PRESET;
  logic req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1, rdata0, rdata1;
  logic done0, err0, done1, err1, busy;

  apb_arb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_arb_master dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .rdata0(rdata0), .done0(done0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .rdata1(rdata1), .done1(done1), .err1(err1),
    .busy(busy), .apb(bus)
  );

  always #5 PCLK = ~PCLK;

  logic [DW-1:0] ram [1024];
  logic [DW-1:0] shadow [1024];
  logic [DW-1:0] exp_rd [2];
  exp_t sbq[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  bit stall = 1'b0;
  bit bus_seen = 1'b0;
  logic [AW-1:0] bus_addr;
  logic bus_we;
  logic [DW-1:0] bus_wdata;

  // APB RAM: PREADY one cycle after PSEL&PENABLE, unless stalled
  always @(posedge PCLK) begin
    if (PRESET) begin
      bus.PREADY <= 1'b0;
    end else begin
      bus.PREADY <= bus.PSEL & bus.PENABLE & ~bus.PREADY & ~stall;
      if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE)
        ram[bus.PADDR[11:2]] <= bus.PWDATA;
    end
    bus.PRDATA <= ram[bus.PADDR[11:2]];
  end

  // Monitor: capture the bus beat, then check each done against the queue
  always @(negedge PCLK) begin
    if (!PRESET) begin
      if (bus.PSEL && bus.PENABLE && bus.PREADY) begin
        bus_seen  = 1'b1;
        bus_addr  = bus.PADDR;
        bus_we    = bus.PWRITE;
        bus_wdata = bus.PWDATA;
      end
      if (done0 || done1) begin
        checks++;
        if (done0 && done1) begin
          errors++;
          $display("FAIL two_dones: done0=%b done1=%b required one", done0, done1);
        end else if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: done0=%b done1=%b, none expected",
                   done0, done1);
        end else begin
          mon_e = sbq.pop_front();
          if ((done1 ? 1 : 0) != mon_e.id) begin
            errors++;
            $display("FAIL done_order: got done%0d required done%0d",
                     done1 ? 1 : 0, mon_e.id);
          end
          checks++;
          if ((mon_e.id == 1 ? err1 : err0) !== mon_e.err) begin
            errors++;
            $display("FAIL err%0d: got %b required %b", mon_e.id,
                     mon_e.id == 1 ? err1 : err0, mon_e.err);
          end
          if (!mon_e.err) begin
            checks++;
            if (!bus_seen || bus_addr !== mon_e.addr || bus_we !== mon_e.we ||
                (mon_e.we && bus_wdata !== mon_e.data)) begin
              errors++;
              $display("FAIL bus_xfer: seen=%b addr=%h we=%b wd=%h required addr=%h we=%b wd=%h",
                       bus_seen, bus_addr, bus_we, bus_wdata,
                       mon_e.addr, mon_e.we, mon_e.data);
            end
            if (!mon_e.we) exp_rd[mon_e.id] = mon_e.data;
          end
          checks++;
          if ((mon_e.id == 1 ? rdata1 : rdata0) !== exp_rd[mon_e.id]) begin
            errors++;
            $display("FAIL rdata%0d: got %h required %h", mon_e.id,
                     mon_e.id == 1 ? rdata1 : rdata0, exp_rd[mon_e.id]);
          end
          checks++;
          if ((mon_e.id == 1 ? rdata0 : rdata1) !== exp_rd[1 - mon_e.id]) begin
            errors++;
            $display("FAIL rdata_other%0d: got %h required %h", 1 - mon_e.id,
                     mon_e.id == 1 ? rdata0 : rdata1, exp_rd[1 - mon_e.id]);
          end
        end
        bus_seen = 1'b0;
      end
    end
  end

  task automatic push(input int id, input bit we,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.id = id; e.we = we; e.addr = a; e.err = 1'b0;
    if (we) begin
      shadow[a[11:2]] = d;
      e.data = d;
    end else begin
      e.data = shadow[a[11:2]];
    end
    sbq.push_back(e);
  endtask

  task automatic start_req(input int id, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (id == 1) begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end
  endtask

  // Wait for doneN, then step past the cycle in which it is high
  task automatic wait_done(input int id, input int budget);
    int n = 0;
    do begin
      @(negedge PCLK);
      n++;
    end while (!(id == 1 ? done1 : done0) && n < budget);
    checks++;
    if (!(id == 1 ? done1 : done0)) begin
      errors++;
      $display("FAIL wait_done%0d: no done within %0d cycles", id, budget);
    end else begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic apply_reset();
    PRESET = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    sbq.delete();
    bus_seen = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge PCLK);
    checks++;
    if ({bus.PSEL, bus.PENABLE, bus.PWRITE, busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000",
               {bus.PSEL, bus.PENABLE, bus.PWRITE, busy});
    end
    checks++;
    if ({done0, done1, err0, err1} !== 4'b0) begin
      errors++;
      $display("FAIL reset_done: got %b required 0000",
               {done0, done1, err0, err1});
    end
    checks++;
    if (rdata0 !== '0 || rdata1 !== '0) begin
      errors++;
      $display("FAIL reset_rdata: got %h %h required 0", rdata0, rdata1);
    end
    checks++;
    if (bus.PADDR !== '0 || bus.PWDATA !== '0) begin
      errors++;
      $display("FAIL reset_bus: got %h %h required 0", bus.PADDR, bus.PWDATA);
    end
  endtask

  task automatic test_write();
    int n = 0;
    push(0, 1'b1, 12'h010, 32'hDEADBEEF);
    start_req(0, 1'b1, 12'h010, 32'hDEADBEEF);
    do begin
      @(negedge PCLK);
      n++;
      if (n == 1) begin
        checks++;
        if ({bus.PSEL, bus.PENABLE, busy} !== 3'b101 || bus.PADDR !== 12'h010) begin
          errors++;
          $display("FAIL setup_phase: sel/en/busy=%b addr=%h required 101 010",
                   {bus.PSEL, bus.PENABLE, busy}, bus.PADDR);
        end
      end
      if (n == 2) begin
        checks++;
        if ({bus.PSEL, bus.PENABLE} !== 2'b11 || bus.PADDR !== 12'h010) begin
          errors++;
          $display("FAIL access_phase: sel/en=%b addr=%h required 11 010",
                   {bus.PSEL, bus.PENABLE}, bus.PADDR);
        end
      end
    end while (!done0 && n < 30);
    checks++;
    if (n != 4 || !done0) begin
      errors++;
      $display("FAIL write_latency: done0 at cycle %0d required 4", n);
    end
    @(posedge PCLK);
    #1;
    req0 = 1'b0;
    checks++;
    if (ram[4] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL ram_word4: got %h required DEADBEEF", ram[4]);
    end
  endtask

  task automatic test_readback();
    @(negedge PCLK);
    push(1, 1'b0, 12'h010, '0);
    start_req(1, 1'b0, 12'h010, '0);
    wait_done(1, 30);
    req1 = 1'b0;
  endtask

  task automatic test_contention();
    apply_reset();
    @(negedge PCLK);
    push(0, 1'b1, 12'h000, 32'hA1A1A1A1);
    push(1, 1'b1, 12'h004, 32'hB2B2B2B2);
    start_req(0, 1'b1, 12'h000, 32'hA1A1A1A1);
    start_req(1, 1'b1, 12'h004, 32'hB2B2B2B2);
    wait_done(0, 40);
    req0 = 1'b0;
    wait_done(1, 40);
    req1 = 1'b0;
    @(negedge PCLK);
    push(0, 1'b0, 12'h004, '0);
    start_req(0, 1'b0, 12'h004, '0);
    wait_done(0, 30);
    req0 = 1'b0;
    @(negedge PCLK);
    push(1, 1'b0, 12'h000, '0);
    push(0, 1'b1, 12'h008, 32'hC3C3C3C3);
    start_req(1, 1'b0, 12'h000, '0);
    start_req(0, 1'b1, 12'h008, 32'hC3C3C3C3);
    wait_done(1, 40);
    req1 = 1'b0;
    wait_done(0, 40);
    req0 = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge PCLK);
    push(0, 1'b1, 12'h00C, 32'h11111111);
    push(0, 1'b1, 12'h008, 32'h22222222);
    start_req(0, 1'b1, 12'h00C, 32'h11111111);
    repeat (2) @(negedge PCLK);
    addr0  = 12'h3FC;
    wdata0 = 32'hBAD0BAD0;
    wait_done(0, 30);
    addr0  = 12'h008;
    wdata0 = 32'h22222222;
    wait_done(0, 30);
    req0 = 1'b0;
    repeat (8) @(negedge PCLK);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL held_queue: %0d pending required 0", sbq.size());
    end
    checks++;
    if (ram[255] !== '0 || ram[3] !== 32'h11111111) begin
      errors++;
      $display("FAIL held_ram: w255=%h w3=%h required 0 11111111",
               ram[255], ram[3]);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit seen_done = 1'b0;
    @(negedge PCLK);
    start_req(0, 1'b1, 12'h020, 32'h5555AAAA);
    do begin
      @(negedge PCLK);
      n++;
    end while (!bus.PENABLE && n < 10);
    PRESET = 1'b1;
    @(negedge PCLK);
    checks++;
    if ({bus.PSEL, bus.PENABLE, busy, done0} !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset: sel/en/busy/done0=%b required 0000",
               {bus.PSEL, bus.PENABLE, busy, done0});
    end
    req0 = 1'b0;
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    bus_seen = 1'b0;
    repeat (4) begin
      @(negedge PCLK);
      if (done0 || done1) seen_done = 1'b1;
    end
    checks++;
    if (seen_done || ram[8] !== '0) begin
      errors++;
      $display("FAIL mid_abort: done=%b w8=%h required 0 0", seen_done, ram[8]);
    end
    push(1, 1'b0, 12'h010, '0);
    start_req(1, 1'b0, 12'h010, '0);
    wait_done(1, 30);
    req1 = 1'b0;
  endtask

  task automatic test_timeout();
    int n = 0;
    int acc = 0;
    exp_t e;
    @(negedge PCLK);
    stall = 1'b1;
`ifdef APB_TIMEOUT_EN
    e.id = 0; e.we = 1'b0; e.addr = 12'h000; e.data = '0; e.err = 1'b1;
    sbq.push_back(e);
    start_req(0, 1'b0, 12'h000, '0);
    do begin
      @(negedge PCLK);
      n++;
      if (bus.PENABLE) acc++;
    end while (!done0 && n < 60);
    checks++;
    if (n != 18 || acc != 16 || bus.PSEL !== 1'b0) begin
      errors++;
      $display("FAIL timeout: done at %0d acc=%0d sel=%b required 18 16 0",
               n, acc, bus.PSEL);
    end
    @(posedge PCLK);
    #1;
    req0 = 1'b0;
    stall = 1'b0;
`else
    e.err = 1'b0;
    start_req(0, 1'b0, 12'h000, '0);
    repeat (40) begin
      @(negedge PCLK);
      if (done0) n++;
    end
    checks++;
    if (bus.PSEL !== 1'b1 || err0 !== 1'b0 || n != 0) begin
      errors++;
      $display("FAIL no_timeout: sel=%b err0=%b dones=%0d required 1 0 0",
               bus.PSEL, err0, n);
    end
    push(0, 1'b0, 12'h000, '0);
    stall = 1'b0;
    wait_done(0, 10);
    req0 = 1'b0;
`endif
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i] = '0;
      shadow[i] = '0;
    end
    bus.PREADY = 1'b0;
    test_reset();
    test_write();
    test_readback();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    repeat (4) @(negedge PCLK);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL final_queue: %0d pending required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
